// File: rtl/imem_load_arbiter.sv
// Shares the single-ported instruction bank between CPU fetches and a streaming program loader.
// While a load runs the CPU is stalled and fetches are held off until the one-cycle DONE state ends.
module imem_load_arbiter #(
    parameter int DEPTH  = 256,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic [31:0]       fetch_addr,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_valid,
    output logic              stall,
    input  logic              load_start,
    input  logic [7:0]        load_base,
    input  logic [8:0]        load_len,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              load_busy,
    output logic              load_done,
    output logic              load_err,
    output logic              mem_memread,
    output logic              mem_memwrite,
    output logic [31:0]       mem_address,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state_q, state_d;
    logic [AW:0]       cnt_q, cnt_d;
    logic [AW-1:0]     base_q, base_d;
    logic [AW:0]       len_q, len_d;
    logic [DATA_W-1:0] fetch_data_q;
    logic              fetch_valid_q, fetch_valid_d;
    logic              load_err_q, load_err_d;

    logic              fetch_go;
    logic              write_go;
    logic              last_word;
    logic              start_bad;
    logic [AW-1:0]     waddr;

    // Range check is done one bit wider than the length so base+len never wraps.
    assign start_bad = (load_len == '0) ||
                       (({2'b00, load_base} + {1'b0, load_len}) > (AW+2)'(DEPTH));
    assign fetch_go  = (state_q == IDLE) && fetch_req && !reset;
    assign write_go  = (state_q == LOAD) && ld_valid && !reset;
    assign last_word = write_go && (cnt_q == len_q - 1'b1);
    assign waddr     = base_q + cnt_q[AW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            base_q        <= '0;
            len_q         <= '0;
            fetch_data_q  <= '0;
            fetch_valid_q <= 1'b0;
            load_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            base_q        <= base_d;
            len_q         <= len_d;
            fetch_valid_q <= fetch_valid_d;
            load_err_q    <= load_err_d;
            if (fetch_go) begin
                fetch_data_q <= mem_readdata;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        base_d        = base_q;
        len_d         = len_q;
        load_err_d    = 1'b0;
        fetch_valid_d = fetch_go;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    if (start_bad) begin
                        load_err_d = 1'b1;
                    end else begin
                        base_d  = load_base;
                        len_d   = load_len;
                        cnt_d   = '0;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                if (write_go) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (last_word) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Fetch and write are mutually exclusive by state, so the bank port never sees both.
    always_comb begin
        stall         = (state_q != IDLE);
        load_busy     = (state_q != IDLE);
        ld_ready      = (state_q == LOAD);
        load_done     = (state_q == DONE);
        fetch_data    = fetch_data_q;
        fetch_valid   = fetch_valid_q;
        load_err      = load_err_q;
        mem_memread   = fetch_go;
        mem_memwrite  = write_go;
        mem_address   = '0;
        mem_writedata = '0;
        if (fetch_go) begin
            mem_address = fetch_addr;
        end else if (write_go) begin
            mem_address   = {{(32-AW-2){1'b0}}, waddr, 2'b00};
            mem_writedata = ld_data;
        end
    end
endmodule

// File: tb/tb_imem_load_arbiter.sv
// Randomized and directed bench for imem_load_arbiter against a word-count reference model.
module tb_imem_load_arbiter;
    logic        clk = 1'b0;
    logic        reset, fetch_req, fetch_valid, stall, load_start;
    logic [31:0] fetch_addr, fetch_data, ld_data, mem_address, mem_writedata, mem_readdata;
    logic [7:0]  load_base;
    logic [8:0]  load_len;
    logic        ld_valid, ld_ready, load_busy, load_done, load_err, mem_memread, mem_memwrite;

    always #5 clk = ~clk;

    imem_load_arbiter dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid), .stall(stall),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready), .load_busy(load_busy),
        .load_done(load_done), .load_err(load_err), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
    );

    // Instruction bank: combinational read, write on rising edge, plus a bench preload port.
    logic [31:0] bank [256];
    logic        pl_we = 1'b0;
    logic [7:0]  pl_idx = '0;
    logic [31:0] pl_data = '0;
    always @(posedge clk) begin
        if (mem_memwrite) bank[mem_address[9:2]] <= mem_writedata;
        else if (pl_we)   bank[pl_idx] <= pl_data;
    end
    assign mem_readdata = bank[mem_address[9:2]];

    int n_chk = 0;
    int n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: expected bank contents and load progress as words remaining.
    logic [31:0] ref_mem [256];
    int          words_left = 0;
    int          next_word = 0;
    bit          m_done = 0, m_fv = 0, m_err = 0;
    logic [31:0] m_fd = '0;

    logic        nx_rst = 0, nx_fr = 0, nx_ls = 0, nx_lv = 0;
    logic [31:0] nx_fa = '0, nx_ld = '0;
    logic [7:0]  nx_lb = '0;
    logic [8:0]  nx_ll = '0;

    int obs_done, obs_stall, obs_wr, obs_err;

    task automatic clr_obs();
        obs_done = 0; obs_stall = 0; obs_wr = 0; obs_err = 0;
    endtask

    task automatic quiet();
        nx_rst = 0; nx_fr = 0; nx_ls = 0; nx_lv = 0;
    endtask

    task automatic tick();
        bit busy, exp_rd, exp_wr;
        @(negedge clk);
        reset = nx_rst; fetch_req = nx_fr; fetch_addr = nx_fa; load_start = nx_ls;
        load_base = nx_lb; load_len = nx_ll; ld_valid = nx_lv; ld_data = nx_ld;
        #1;
        busy = (words_left > 0) || m_done;
        check_eq("stall", stall, busy);
        check_eq("ld_ready", ld_ready, words_left > 0);
        check_eq("load_busy", load_busy, busy);
        check_eq("load_done", load_done, m_done);
        check_eq("fetch_valid", fetch_valid, m_fv);
        check_eq("fetch_data", fetch_data, m_fd);
        check_eq("load_err", load_err, m_err);
        exp_rd = !nx_rst && !busy && nx_fr;
        exp_wr = !nx_rst && (words_left > 0) && nx_lv;
        check_eq("memread", mem_memread, exp_rd);
        check_eq("memwrite", mem_memwrite, exp_wr);
        check_eq("rw_exclusive", mem_memread & mem_memwrite, 0);
        if (exp_rd) check_eq("rd_addr", mem_address, nx_fa);
        if (exp_wr) begin
            check_eq("wr_addr", mem_address, next_word * 4);
            check_eq("wr_data", mem_writedata, nx_ld);
        end
        obs_done += int'(load_done); obs_stall += int'(stall);
        obs_wr += int'(mem_memwrite); obs_err += int'(load_err);

        if (nx_rst) begin
            words_left = 0; m_done = 0; m_fv = 0; m_fd = '0; m_err = 0;
        end else if (m_done) begin
            m_done = 0; m_fv = 0; m_err = 0;
        end else if (words_left > 0) begin
            m_fv = 0; m_err = 0;
            if (nx_lv) begin
                ref_mem[next_word] = nx_ld;
                next_word++;
                words_left--;
                if (words_left == 0) m_done = 1;
            end
        end else begin
            m_fv = nx_fr;
            if (nx_fr) m_fd = ref_mem[nx_fa[9:2]];
            m_err = 0;
            if (nx_ls) begin
                if (nx_ll == 0 || int'(nx_lb) + int'(nx_ll) > 256) m_err = 1;
                else begin
                    next_word = int'(nx_lb);
                    words_left = int'(nx_ll);
                end
            end
        end
    endtask

    initial begin
        reset = 1; fetch_req = 0; fetch_addr = '0; load_start = 0; load_base = '0;
        load_len = '0; ld_valid = 0; ld_data = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = (i == 2) ? 32'h0022_1820 : $urandom;
            @(negedge clk);
            pl_we = 1; pl_idx = 8'(i); pl_data = ref_mem[i];
        end
        @(negedge clk);
        pl_we = 0;
        @(posedge clk);

        // Fetch: word 2, then 0 and 4 back to back
        quiet(); nx_fr = 1; nx_fa = 32'h8; tick();
        nx_fa = 32'h0; tick();
        check_eq("fetch_word2", fetch_data, 32'h0022_1820);
        nx_fa = 32'h4; tick();
        quiet(); tick(); tick();

        // Load with a gap between the second and third word
        clr_obs();
        nx_ls = 1; nx_lb = 8'd4; nx_ll = 9'd3; tick();
        quiet(); nx_lv = 1; nx_ld = 32'hA; tick();
        nx_ld = 32'hB; tick();
        nx_lv = 0; tick();
        nx_lv = 1; nx_ld = 32'hC; tick();
        quiet(); tick(); tick();
        check_eq("gap_done_pulses", obs_done, 1);
        check_eq("gap_stall_cycles", obs_stall, 5);
        check_eq("gap_writes", obs_wr, 3);
        nx_fr = 1; nx_fa = 32'h14; tick();
        quiet(); tick();
        check_eq("gap_fetch_0x14", fetch_data, 32'hB);

        // Rejects, then an exactly-fitting load at the top of the bank
        clr_obs();
        nx_ls = 1; nx_lb = 8'd7; nx_ll = 9'd0; nx_lv = 1; nx_ld = 32'hDEAD; tick();
        nx_ls = 0; tick(); tick();
        nx_ls = 1; nx_lb = 8'd250; nx_ll = 9'd10; tick();
        nx_ls = 0; tick(); tick();
        check_eq("rej_err_pulses", obs_err, 2);
        check_eq("rej_writes", obs_wr, 0);
        check_eq("rej_stall", obs_stall, 0);
        clr_obs();
        quiet(); nx_ls = 1; nx_lb = 8'd250; nx_ll = 9'd6; tick();
        quiet(); nx_lv = 1;
        for (int i = 0; i < 6; i++) begin nx_ld = $urandom; tick(); end
        quiet(); tick(); tick();
        check_eq("fit_writes", obs_wr, 6);
        check_eq("fit_stall", obs_stall, 7);
        check_eq("fit_err", obs_err, 0);

        // Fetch and load_start together; fetch held and second start during LOAD
        clr_obs();
        nx_fr = 1; nx_fa = 32'h0; nx_ls = 1; nx_lb = 8'd10; nx_ll = 9'd2; tick();
        nx_ls = 0; tick();
        check_eq("sim_fetch_valid", fetch_valid, 1);
        check_eq("sim_stall", stall, 1);
        tick();
        nx_ls = 1; nx_lb = 8'd0; nx_ll = 9'd5; nx_lv = 1; nx_ld = $urandom; tick();
        nx_ls = 0; nx_ld = $urandom; tick();
        nx_lv = 0; tick(); tick();
        quiet(); tick();
        check_eq("sim_writes", obs_wr, 2);
        check_eq("sim_err", obs_err, 0);

        // Reset in the middle of a load
        clr_obs();
        nx_ls = 1; nx_lb = 8'd0; nx_ll = 9'd4; tick();
        quiet(); nx_lv = 1; nx_ld = 32'h1111_0000; tick();
        nx_ld = 32'h2222_0000; tick();
        nx_rst = 1; nx_fr = 1; nx_ld = 32'h3333_0000; tick(); tick();
        quiet(); tick();
        check_eq("rst_stall", stall, 0);
        check_eq("rst_ld_ready", ld_ready, 0);
        check_eq("rst_fetch_valid", fetch_valid, 0);
        check_eq("rst_fetch_data", fetch_data, 0);
        for (int i = 0; i < 4; i++) begin nx_fr = 1; nx_fa = 32'(i * 4); tick(); end
        quiet(); tick();
        check_eq("rst_no_done", obs_done, 0);
        check_eq("rst_word1", ref_mem[1], 32'h2222_0000);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            int r;
            nx_rst = ($urandom_range(0, 99) == 0);
            nx_fr  = 1'($urandom_range(0, 1));
            nx_fa  = $urandom;
            nx_ls  = ($urandom_range(0, 15) == 0);
            nx_lb  = 8'($urandom);
            r = $urandom_range(0, 9);
            if (r == 0)      nx_ll = 9'd0;
            else if (r == 1) nx_ll = 9'($urandom_range(0, 511));
            else             nx_ll = 9'($urandom_range(1, 8));
            nx_lv  = ($urandom_range(0, 3) != 0);
            nx_ld  = $urandom;
            tick();
        end
        quiet(); nx_rst = 1; tick();
        quiet();
        for (int i = 0; i < 256; i++) begin nx_fr = 1; nx_fa = 32'(i * 4); tick(); end
        quiet(); tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
